// File: rtl/debounce_switch_toggle_if.sv
// Switch/LED bundle for debounce_switch_toggle.
// The slave side is the debouncer: it takes the raw switch levels and drives
// the clean levels, release pulses, LED toggles and the release counter.
interface debounce_switch_toggle_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Switch_3;
    logic       i_Switch_4;
    logic [3:0] o_Switch_Clean;
    logic [3:0] o_Release;
    logic       o_LED_1;
    logic       o_LED_2;
    logic       o_LED_3;
    logic       o_LED_4;
    logic [7:0] o_Release_Count;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_Switch_Clean, o_Release,
        input  o_LED_1, o_LED_2, o_LED_3, o_LED_4,
        input  o_Release_Count
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_Switch_Clean, o_Release,
        output o_LED_1, o_LED_2, o_LED_3, o_LED_4,
        output o_Release_Count
    );
endinterface

// File: rtl/debounce_switch_toggle.sv
// Four-channel switch debouncer with release-driven LED toggles and a
// saturating release counter.
// A change is accepted only after DEBOUNCE_LIMIT consecutive samples differ
// from the current clean level; any reversion restarts the count.
// Optional macro SWITCH_SYNC_EN inserts a two-flop synchronizer on every raw
// switch input (two extra cycles of latency). Without it the raw levels feed
// the debounce counters directly. Every output is a flop.
module debounce_switch_toggle #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    debounce_switch_toggle_if.slave sw_if
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [3:0] sw_raw;
    logic [3:0] sw_smp;

    assign sw_raw = {sw_if.i_Switch_4, sw_if.i_Switch_3,
                     sw_if.i_Switch_2, sw_if.i_Switch_1};

`ifdef SWITCH_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    // Two-flop synchronizer; cleared by reset so no stale level survives it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign sw_smp = sync_q2;
`else
    assign sw_smp = sw_raw;
`endif

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       clean_q;
    logic [3:0]       clean_d;
    logic [3:0]       rel_q;
    logic [3:0]       rel_d;
    logic [3:0]       led_q;
    logic [3:0]       led_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;
    logic [2:0]       rel_num;
    logic [8:0]       count_sum;

    // Next-state: per-channel stability counters, release detect, LED toggle
    // and saturating accumulation of the number of releases this edge.
    always_comb begin
        clean_d = clean_q;
        rel_num = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sw_smp[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sw_smp[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rel_d = clean_q & ~clean_d;
        led_d = led_q ^ rel_d;
        for (int i = 0; i < 4; i++) begin
            rel_num = rel_num + {2'b00, rel_d[i]};
        end
        count_sum = {1'b0, count_q} + {6'd0, rel_num};
        count_d   = count_sum[8] ? 8'hFF : count_sum[7:0];
    end

    // State registers; reset drops partial counts without producing a pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q <= '0;
            rel_q   <= '0;
            led_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q <= clean_d;
            rel_q   <= rel_d;
            led_q   <= led_d;
            count_q <= count_d;
        end
    end

    assign sw_if.o_Switch_Clean  = clean_q;
    assign sw_if.o_Release       = rel_q;
    assign sw_if.o_LED_1         = led_q[0];
    assign sw_if.o_LED_2         = led_q[1];
    assign sw_if.o_LED_3         = led_q[2];
    assign sw_if.o_LED_4         = led_q[3];
    assign sw_if.o_Release_Count = count_q;

endmodule

// File: tb/tb_debounce_switch_toggle.sv
// Self-checking bench for debounce_switch_toggle (DEBOUNCE_LIMIT = 4).
// Reference model: a switch level is accepted once the last LIMIT debounce
// samples all disagree with the clean level; sample history restarts on reset.
module tb_debounce_switch_toggle;

    localparam int LIMIT = 4;
`ifdef SWITCH_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = LIMIT + SYNC;

    logic i_Clk   = 1'b0;
    logic i_Reset = 1'b1;

    always #5 i_Clk = ~i_Clk;

    debounce_switch_toggle_if sw_if ();

    debounce_switch_toggle #(.DEBOUNCE_LIMIT(LIMIT)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .sw_if   (sw_if)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] m_clean;
    logic [3:0] m_rel;
    logic [3:0] m_led;
    int         m_count;
    logic [3:0] hist[$];
    logic [3:0] pipe[$];

    // Reference model update for one rising edge.
    task automatic model_edge(input logic [3:0] sw, input logic rst);
        logic [3:0] eff;
        logic [3:0] nxt;
        bit         all_diff;
        if (rst) begin
            m_clean = '0;
            m_rel   = '0;
            m_led   = '0;
            m_count = 0;
            hist.delete();
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(4'h0);
        end else begin
            if (SYNC == 0) begin
                eff = sw;
            end else begin
                pipe.push_back(sw);
                eff = pipe.pop_front();
            end
            hist.push_back(eff);
            if (hist.size() > LIMIT) void'(hist.pop_front());
            nxt = m_clean;
            for (int b = 0; b < 4; b++) begin
                all_diff = (hist.size() == LIMIT);
                foreach (hist[k]) if (hist[k][b] == m_clean[b]) all_diff = 0;
                if (all_diff) nxt[b] = ~m_clean[b];
            end
            m_rel   = m_clean & ~nxt;
            m_led   = m_led ^ m_rel;
            m_count = m_count + $countones(m_rel);
            if (m_count > 255) m_count = 255;
            m_clean = nxt;
        end
    endtask

    task automatic tick(input logic [3:0] sw, input logic rst);
        sw_if.i_Switch_1 = sw[0];
        sw_if.i_Switch_2 = sw[1];
        sw_if.i_Switch_3 = sw[2];
        sw_if.i_Switch_4 = sw[3];
        i_Reset          = rst;
        @(posedge i_Clk);
        model_edge(sw, rst);
        #1;
    endtask

    function automatic logic [19:0] obs();
        return {sw_if.o_Switch_Clean, sw_if.o_Release,
                sw_if.o_LED_4, sw_if.o_LED_3, sw_if.o_LED_2, sw_if.o_LED_1,
                sw_if.o_Release_Count};
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] c;
        c = m_count[7:0];
        return {m_clean, m_rel, m_led, c};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick(4'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(4'h0, 1'b0);
            checks++;
            if (obs() !== 20'h0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=00000", k, obs());
            end
        end
    endtask

    task automatic test_press_release();
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(4'h1, 1'b0);
            checks++;
            if (sw_if.o_Switch_Clean[0] !== (k >= LAT)) begin
                errors++;
                $display("FAIL press_latency k=%0d got=%b exp=%b", k, sw_if.o_Switch_Clean[0], (k >= LAT));
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL press_model k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
        end
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(4'h0, 1'b0);
            checks++;
            if (sw_if.o_Switch_Clean[0] !== (k < LAT) ||
                sw_if.o_Release !== ((k == LAT) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL release_pulse k=%0d got clean=%b rel=%b", k, sw_if.o_Switch_Clean[0], sw_if.o_Release);
            end
            if (k == LAT) begin
                checks++;
                if (sw_if.o_LED_1 !== 1'b1 || sw_if.o_Release_Count !== 8'd1) begin
                    errors++;
                    $display("FAIL release_led_count got led=%b cnt=%0d exp led=1 cnt=1", sw_if.o_LED_1, sw_if.o_Release_Count);
                end
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL release_model k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b1111_1111_0111;
        for (int k = 0; k < 12; k++) begin
            tick({2'b00, pat[k], 1'b0}, 1'b0);
            checks++;
            if (sw_if.o_Switch_Clean[1] !== (k >= 7 + SYNC)) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, sw_if.o_Switch_Clean[1], (k >= 7 + SYNC));
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
        end
        for (int k = 0; k < LAT + 2; k++) tick(4'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int         base;
        logic [3:0] led0;
        for (int k = 0; k < LAT + 1; k++) tick(4'hF, 1'b0);
        base = m_count;
        led0 = m_led;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(4'h0, 1'b0);
            if (k == LAT) begin
                checks++;
                if (sw_if.o_Release !== 4'hF ||
                    sw_if.o_Release_Count !== 8'(base + 4) ||
                    {sw_if.o_LED_4, sw_if.o_LED_3, sw_if.o_LED_2, sw_if.o_LED_1} !== ~led0) begin
                    errors++;
                    $display("FAIL simultaneous got rel=%b cnt=%0d exp rel=1111 cnt=%0d", sw_if.o_Release, sw_if.o_Release_Count, base + 4);
                end
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL simultaneous_model k=%0d got=%h exp=%h", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2 + SYNC; k++) tick(4'h1, 1'b0);
        tick(4'h1, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(4'h1, 1'b0);
            checks++;
            if (sw_if.o_Switch_Clean[0] !== (k >= LAT) || sw_if.o_Release !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got clean=%b rel=%b exp clean=%b rel=0", k, sw_if.o_Switch_Clean[0], sw_if.o_Release, (k >= LAT));
            end
        end
        for (int k = 0; k < LAT + 1; k++) tick(4'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] sw;
        int         hold;
        logic       rst;
        for (int n = 0; n < 150; n++) begin
            sw   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, LAT + 2);
            for (int h = 0; h < hold; h++) begin
                rst = ($urandom_range(0, 80) == 0);
                tick(sw, rst);
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random n=%0d h=%0d got=%h exp=%h", n, h, obs(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        tick(4'h0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < LAT; k++) tick(4'h4, 1'b0);
            for (int k = 0; k < LAT; k++) begin
                tick(4'h0, 1'b0);
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("FAIL saturation_model n=%0d got=%h exp=%h", n, obs(), exp_vec());
                end
            end
        end
        tick(4'h0, 1'b0);
        checks++;
        if (sw_if.o_Release_Count !== 8'd255 || sw_if.o_LED_3 !== 1'b0) begin
            errors++;
            $display("FAIL saturation_final got cnt=%0d led3=%b exp cnt=255 led3=0", sw_if.o_Release_Count, sw_if.o_LED_3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sw_if.i_Switch_1 = 1'b0;
        sw_if.i_Switch_2 = 1'b0;
        sw_if.i_Switch_3 = 1'b0;
        sw_if.i_Switch_4 = 1'b0;
        model_edge(4'h0, 1'b1);
        test_reset();
        test_press_release();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_switch_toggle.md
DEBOUNCE_SWITCH_TOGGLE -- requirements
Module: debounce_switch_toggle

Interface
REQ-001 Parameter DEBOUNCE_LIMIT, default 250000, gives the stable-input clock cycles required before a switch change is accepted (10 ms at 25 MHz); legal range 2..2^24.
REQ-002 i_Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  reset; synchronous, active-high.
REQ-004 i_Switch_1 .. i_Switch_4  input  1 each  raw mechanical switch levels, 1 = pressed.
REQ-005 o_Switch_Clean  output  4  debounced switch levels; bit 0 = switch 1 .. bit 3 = switch 4.
REQ-006 o_Release  output  4  one-cycle pulse per switch on a debounced 1->0 transition.
REQ-007 o_LED_1 .. o_LED_4  output  1 each  toggle state of the matching switch.
REQ-008 o_Release_Count  output  8  total debounced releases since reset, saturating.

Function
REQ-009 Each of the four channels SHALL have an independent debounce counter of width clog2(DEBOUNCE_LIMIT) and a clean-state register.
REQ-010 Per edge, if sampled input equals clean state, the counter SHALL clear to 0.
REQ-011 If sampled input differs from clean state and counter < DEBOUNCE_LIMIT-1, the counter SHALL increment by 1.
REQ-012 If sampled input differs and counter == DEBOUNCE_LIMIT-1, clean state SHALL take the sampled value and the counter SHALL clear to 0.
REQ-013 Latency: a level held stable from the first edge that samples it SHALL appear on o_Switch_Clean exactly DEBOUNCE_LIMIT edges later (excluding synchronizer delay, REQ-022).
REQ-014 A pulse or glitch lasting fewer than DEBOUNCE_LIMIT sampled cycles SHALL NOT change o_Switch_Clean; any reversion restarts the count from 0.
REQ-015 o_Release[n] SHALL be high for exactly one cycle, in the same cycle o_Switch_Clean[n] first reads 0 after reading 1; press (0->1) SHALL NOT pulse.
REQ-016 o_LED_n SHALL invert on the same edge that raises o_Release[n-1], so the new LED value is visible in the pulse cycle.
REQ-017 o_Release_Count SHALL add the number of bits set in the next-cycle o_Release value (0..4) per edge, saturating at 255; no wrap-around.
REQ-018 Simultaneous releases on multiple switches in one cycle SHALL each toggle their own LED and all be counted.
REQ-019 All outputs SHALL be driven directly from registers; no combinational path from i_Switch_n to any output.

Reset
REQ-020 While i_Reset is high at an edge: counters, o_Switch_Clean, o_Release, o_LED_1..4, o_Release_Count SHALL all become 0, and synchronizer flops (when present) SHALL become 0.
REQ-021 Reset mid-debounce SHALL discard partial counts; after deassertion a switch held at 1 SHALL need a full DEBOUNCE_LIMIT count to reach clean 1, with no o_Release pulse generated by the reset itself.

Configuration
REQ-022 Macro SWITCH_SYNC_EN defined: each i_Switch_n SHALL pass through a two-flop synchronizer before the debounce logic, adding exactly 2 cycles latency to REQ-013.
REQ-023 SWITCH_SYNC_EN undefined: i_Switch_n SHALL feed the debounce logic directly with no added latency; all other behaviour is identical.

Verification (DEBOUNCE_LIMIT=4, SWITCH_SYNC_EN undefined unless stated)
REQ-024 Reset, then all switches 0 for 10 cycles -> all outputs 0, o_Release_Count = 0.
REQ-025 i_Switch_1 0->1 held -> o_Switch_Clean[0]=1 exactly 4 edges after first sampling edge; hold 1 then drop to 0 -> 4 edges later o_Switch_Clean[0]=0, o_Release=4'b0001 for one cycle, o_LED_1=1, count=1.
REQ-026 i_Switch_2 bounce 1,1,1,0,1,1,1,1 -> clean changes only after the final 4-cycle run; no change from the initial 3-cycle run.
REQ-027 Switches 1..4 released on the same cycle after debounced press -> o_Release=4'b1111 one cycle, all LEDs toggle, count increments by 4.
REQ-028 300 release cycles on switch 3 -> o_Release_Count holds 255; o_LED_3 = 0 (even number of toggles).
REQ-029 SWITCH_SYNC_EN defined, REQ-025 stimulus -> every response delayed exactly 2 cycles; i_Reset asserted at count 2 of a debounce -> clean stays 0, no pulse.
